// File: rtl/tc_timer_pkg.sv
// Shared definitions for the memory-mapped timer/counter: FSM encoding,
// register offsets, CTRL bit positions and mode constants.
package tc_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } tc_state_e;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   localparam int CTRL_W       = 4;
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   localparam logic [1:0] MODE_ONESHOT  = 2'b00;
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   // Per-cycle actions decoded from the FSM state; drives the datapath.
   typedef struct packed {
      logic load;     // COUNT <= PRESET
      logic dec;      // COUNT <= COUNT - 1
      logic fire;     // COUNT <= 0, irq_flag <= 1
      logic rearm;    // periodic expiry: irq_flag <= 0
      logic en_clr;   // one-shot expiry: CTRL.EN <= 0
   } tc_ctl_t;

   function automatic logic is_periodic(input logic [1:0] mode);
      return (mode == MODE_PERIODIC);
   endfunction

endpackage

// File: rtl/tc_byte_merge.sv
// Per-lane write merge: bit b takes wdata when byteen[b/8] is set, else keeps
// the old value. Width need not be a whole number of bytes.
module tc_byte_merge
   import tc_timer_pkg::*;
#(
   parameter int W  = 32,
   parameter int NB = (W + 7) / 8
)
(
   input  logic [W-1:0]  i_old,
   input  logic [W-1:0]  i_wdata,
   input  logic [NB-1:0] i_byteen,
   output logic [W-1:0]  o_merged
);

   for (genvar b = 0; b < W; b++) begin : g_bit
      assign o_merged[b] = i_byteen[b / 8] ? i_wdata[b] : i_old[b];
   end

endmodule

// File: rtl/tc_timer.sv
// Memory-mapped down-counter timer with one-shot and periodic modes and a
// maskable interrupt. Reads are combinational for same-cycle M-stage use.
module tc_timer
   import tc_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   output logic [1:0]  dbg_state
);

   tc_state_e          r_state;
   tc_state_e          w_next_state;
   tc_ctl_t            w_ctl;
   logic [CTRL_W-1:0]  r_ctrl;
   logic [31:0]        r_preset;
   logic [31:0]        r_count;
   logic               r_irq_flag;

   logic               w_sel;
   logic               w_wr;
   logic               w_wr_ctrl;
   logic               w_wr_preset;
   logic [CTRL_W-1:0]  w_ctrl_merged;
   logic [31:0]        w_preset_merged;
   logic               w_en;
   logic [1:0]         w_mode;
   logic               w_unused;

   // Word select only; the byte offset within a word plays no part.
   assign w_unused    = ^addr[1:0];
   assign w_sel       = (addr[31:4] == BASE_ADDR[31:4]);
   assign w_wr        = we & w_sel & (|byteen);
   assign w_wr_ctrl   = w_wr & (addr[3:2] == REG_CTRL);
   assign w_wr_preset = w_wr & (addr[3:2] == REG_PRESET);

   assign w_en   = r_ctrl[CTRL_EN];
   assign w_mode = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

   tc_byte_merge #(.W(CTRL_W)) u_ctrl_merge (
      .i_old    (r_ctrl),
      .i_wdata  (wdata[CTRL_W-1:0]),
      .i_byteen (byteen[0:0]),
      .o_merged (w_ctrl_merged)
   );

   tc_byte_merge #(.W(32)) u_preset_merge (
      .i_old    (r_preset),
      .i_wdata  (wdata),
      .i_byteen (byteen),
      .o_merged (w_preset_merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_en) w_next_state = ST_LOAD;
         ST_LOAD: w_next_state = ST_CNT;
         ST_CNT: begin
            if (!w_en)                  w_next_state = ST_IDLE;
            else if (r_count <= 32'd1)  w_next_state = ST_INT;
         end
         ST_INT: w_next_state = is_periodic(w_mode) ? ST_LOAD : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ctl        = '0;
      w_ctl.load   = (r_state == ST_LOAD);
      w_ctl.dec    = (r_state == ST_CNT) & w_en & (r_count > 32'd1);
      w_ctl.fire   = (r_state == ST_CNT) & w_en & (r_count <= 32'd1);
      w_ctl.rearm  = (r_state == ST_INT) & is_periodic(w_mode);
      w_ctl.en_clr = (r_state == ST_INT) & ~is_periodic(w_mode);
   end

   // A CPU write to CTRL in the INT cycle overrides the one-shot EN clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl <= '0;
      end else if (w_wr_ctrl) begin
         r_ctrl <= w_ctrl_merged;
      end else if (w_ctl.en_clr) begin
         r_ctrl[CTRL_EN] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_preset <= '0;
      end else if (w_wr_preset) begin
         r_preset <= w_preset_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_ctl.load) begin
         r_count <= r_preset;
      end else if (w_ctl.dec) begin
         r_count <= r_count - 32'd1;
      end else if (w_ctl.fire) begin
         r_count <= '0;
      end
   end

   // Expiry sets the flag even if software writes in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irq_flag <= 1'b0;
      end else if (w_ctl.fire) begin
         r_irq_flag <= 1'b1;
      end else if (w_ctl.rearm || w_wr_ctrl || w_wr_preset) begin
         r_irq_flag <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      if (w_sel) begin
         case (addr[3:2])
            REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
            REG_PRESET: rdata = r_preset;
            REG_COUNT:  rdata = r_count;
            REG_RSVD:   rdata = '0;
            default:    rdata = '0;
         endcase
      end
   end

   assign irq       = r_irq_flag & r_ctrl[CTRL_IM];
   assign dbg_state = r_state;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: register access, one-shot, periodic, masking,
// byte lanes and reset behaviour, checked against a queue of expected values.
module tb_tc_timer;

   localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
   localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [1:0]  dbg_state;

   logic [31:0] exp_q[$];
   int          n_cmp;
   int          n_fail;

   tc_timer #(.BASE_ADDR(32'h0000_7F00)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .we        (we),
      .byteen    (byteen),
      .wdata     (wdata),
      .rdata     (rdata),
      .irq       (irq),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr   = a;
      wdata  = d;
      byteen = be;
      we     = 1'b1;
      @(posedge clk);
      #1;
      we     = 1'b0;
      byteen = 4'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      we    = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: observed %h, scoreboard had no expected value", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] e);
      exp_q.push_back(e);
      addr = a;
      we   = 1'b0;
      #1;
      check(tag, rdata);
   endtask

   task automatic irq_check(input string tag, input logic e);
      exp_q.push_back({31'd0, e});
      check(tag, {31'd0, irq});
   endtask

   task automatic state_check(input string tag, input logic [1:0] e);
      exp_q.push_back({30'd0, e});
      check(tag, {30'd0, dbg_state});
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b1;
      addr   = '0;
      we     = 1'b0;
      byteen = '0;
      wdata  = '0;

      // Reset state and window decode
      do_reset();
      rd_check("rst_ctrl",   A_CTRL,   32'h0);
      rd_check("rst_preset", A_PRESET, 32'h0);
      rd_check("rst_count",  A_COUNT,  32'h0);
      rd_check("rst_outwin", 32'h0000_7F10, 32'h0);
      irq_check("rst_irq", 1'b0);
      state_check("rst_state", 2'd0);

      // One-shot, N=5: COUNT 5..0, irq rises 7 edges after the CTRL write
      wr(A_PRESET, 32'd5, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      tick(1);
      state_check("os_load", 2'd1);
      tick(1);
      rd_check("os_count5", A_COUNT, 32'd5);
      irq_check("os_irq_e2", 1'b0);
      for (int i = 1; i <= 5; i++) begin
         tick(1);
         rd_check($sformatf("os_count%0d", 5 - i), A_COUNT, 32'(5 - i));
         irq_check($sformatf("os_irq_e%0d", i + 2), (i == 5));
      end
      tick(1);
      rd_check("os_ctrl_en_clr", A_CTRL, 32'h8);
      state_check("os_idle", 2'd0);
      tick(3);
      irq_check("os_irq_held", 1'b1);
      wr(A_PRESET, 32'd5, 4'hF);
      irq_check("os_irq_clr_preset_wr", 1'b0);

      // Periodic, N=3: 1-cycle pulse every 5 cycles, EN stays set
      do_reset();
      wr(A_PRESET, 32'd3, 4'hF);
      wr(A_CTRL, 32'hB, 4'hF);
      for (int k = 1; k <= 16; k++) begin
         tick(1);
         irq_check($sformatf("per_irq_e%0d", k), (k == 5 || k == 10 || k == 15));
      end
      rd_check("per_ctrl", A_CTRL, 32'hB);

      // Masked expiry, then unmask via CTRL write that clears flag and restarts
      do_reset();
      wr(A_PRESET, 32'd2, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      tick(6);
      rd_check("msk_count", A_COUNT, 32'h0);
      rd_check("msk_ctrl", A_CTRL, 32'h0);
      irq_check("msk_irq", 1'b0);
      wr(A_CTRL, 32'h9, 4'hF);
      irq_check("unmsk_irq_f0", 1'b0);
      tick(1);
      irq_check("unmsk_irq_f1", 1'b0);
      state_check("unmsk_load", 2'd1);
      tick(3);
      irq_check("unmsk_irq_fire", 1'b1);

      // CTRL write in the INT cycle keeps the written EN
      do_reset();
      wr(A_PRESET, 32'd1, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      tick(3);
      state_check("int_state", 2'd3);
      irq_check("int_irq", 1'b1);
      wr(A_CTRL, 32'h9, 4'hF);
      rd_check("int_ctrl_kept", A_CTRL, 32'h9);
      irq_check("int_irq_clr", 1'b0);
      state_check("int_to_idle", 2'd0);

      // Byte lanes, read-only COUNT, reserved word, window and offset decode
      do_reset();
      wr(A_PRESET, 32'h1122_3344, 4'hF);
      wr(A_PRESET, 32'hAABB_CCDD, 4'b0101);
      rd_check("lane_merge", A_PRESET, 32'h11BB_33DD);
      wr(A_PRESET, 32'hFFFF_FFFF, 4'b0000);
      rd_check("lane_none", A_PRESET, 32'h11BB_33DD);
      wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
      rd_check("count_ro", A_COUNT, 32'h0);
      wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
      rd_check("rsvd_zero", A_RSVD, 32'h0);
      wr(32'h0000_7F14, 32'hDEAD_BEEF, 4'hF);
      rd_check("outwin_wr", A_PRESET, 32'h11BB_33DD);
      rd_check("offset_ign", 32'h0000_7F06, 32'h11BB_33DD);

      // Reset mid-count
      do_reset();
      wr(A_PRESET, 32'd10, 4'hF);
      wr(A_CTRL, 32'h9, 4'hF);
      tick(4);
      rd_check("mid_count", A_COUNT, 32'd8);
      state_check("mid_state", 2'd2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      rd_check("mid_rst_count", A_COUNT, 32'h0);
      rd_check("mid_rst_ctrl", A_CTRL, 32'h0);
      state_check("mid_rst_state", 2'd0);
      irq_check("mid_rst_irq", 1'b0);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: observed %0d leftover entries, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
